dcache_port_arbiter: RTL

Arbitrates two core-side requesters onto the single data-cache core bus: port 0 is the Memory-stage load path, port 1 is the Writeback-stage store path. The block registers the winning request, drives the cache request and response handshake, and returns the one-beat response to the port that owns it. Only one transaction is outstanding at a time. Round-robin arbitration keeps either stage from starving the other.

---
 rtl/dcache_port_arbiter_if.sv | 46 ++++
 rtl/dcache_port_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter_if.sv
// Core-side bus bundle for dcache_port_arbiter.
// Carries both requester ports (m0 = Memory-stage loads, m1 = Writeback-stage stores)
// and the single data-cache core bus.
//   master : arbiter side (consumes requests and cache responses, drives acks and the cache bus)
//   slave  : environment side (requesters plus cache)
interface dcache_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TAG_WIDTH  = 13
);
  logic                  m0_reqcyc;
  logic [ADDR_WIDTH-1:0] m0_req;
  logic [TAG_WIDTH-1:0]  m0_reqtag;
  logic                  m0_reqack;
  logic                  m0_respcyc;
  logic [DATA_WIDTH-1:0] m0_resp;

  logic                  m1_reqcyc;
  logic [ADDR_WIDTH-1:0] m1_req;
  logic [TAG_WIDTH-1:0]  m1_reqtag;
  logic                  m1_reqack;
  logic                  m1_respcyc;
  logic [DATA_WIDTH-1:0] m1_resp;

  logic                  c_reqcyc;
  logic [ADDR_WIDTH-1:0] c_req;
  logic [TAG_WIDTH-1:0]  c_reqtag;
  logic                  c_reqack;
  logic                  c_respcyc;
  logic [DATA_WIDTH-1:0] c_resp;
  logic                  c_respack;

  modport master (
    input  m0_reqcyc, m0_req, m0_reqtag, m1_reqcyc, m1_req, m1_reqtag,
    input  c_reqack, c_respcyc, c_resp,
    output m0_reqack, m0_respcyc, m0_resp, m1_reqack, m1_respcyc, m1_resp,
    output c_reqcyc, c_req, c_reqtag, c_respack
  );

  modport slave (
    output m0_reqcyc, m0_req, m0_reqtag, m1_reqcyc, m1_req, m1_reqtag,
    output c_reqack, c_respcyc, c_resp,
    input  m0_reqack, m0_respcyc, m0_resp, m1_reqack, m1_respcyc, m1_resp,
    input  c_reqcyc, c_req, c_reqtag, c_respack
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Two-port round-robin arbiter in front of the data-cache core bus.
// One transaction outstanding at a time; the winning request is registered onto the
// cache bus and the single response beat is returned to the owning port only.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   bus (master modport)  : requester ports m0/m1 and the cache bus
//   busy                  : high whenever the FSM is not idle
//   owner                 : port owning the current/last transaction
//   grant_cnt0/grant_cnt1 : wrapping grant counters per port
module dcache_port_arbiter (
  input  logic                  clk,
  input  logic                  reset,
  dcache_port_arbiter_if.master bus,
  output logic                  busy,
  output logic                  owner,
  output logic [31:0]           grant_cnt0,
  output logic [31:0]           grant_cnt1
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e state;
  logic   lastGrant;
  logic   winner;
  logic [$bits(bus.c_resp)-1:0] respData;

  // On a tie the port that did not win last time goes; otherwise whoever is asking.
  assign winner = (bus.m0_reqcyc && bus.m1_reqcyc) ? ~lastGrant : bus.m1_reqcyc;

  // Both ports see the same response register; only the owner's respcyc qualifies it.
  assign bus.m0_resp = respData;
  assign bus.m1_resp = respData;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= StIdle;
      lastGrant      <= 1'b1;
      owner          <= 1'b0;
      busy           <= 1'b0;
      grant_cnt0     <= '0;
      grant_cnt1     <= '0;
      respData       <= '0;
      bus.c_reqcyc   <= 1'b0;
      bus.c_req      <= '0;
      bus.c_reqtag   <= '0;
      bus.c_respack  <= 1'b0;
      bus.m0_reqack  <= 1'b0;
      bus.m1_reqack  <= 1'b0;
      bus.m0_respcyc <= 1'b0;
      bus.m1_respcyc <= 1'b0;
    end else begin
      bus.m0_reqack  <= 1'b0;
      bus.m1_reqack  <= 1'b0;
      bus.m0_respcyc <= 1'b0;
      bus.m1_respcyc <= 1'b0;
      bus.c_respack  <= 1'b0;
      case (state)
        StIdle: begin
          if (bus.m0_reqcyc || bus.m1_reqcyc) begin
            bus.c_req     <= winner ? bus.m1_req : bus.m0_req;
            bus.c_reqtag  <= winner ? bus.m1_reqtag : bus.m0_reqtag;
            bus.c_reqcyc  <= 1'b1;
            bus.m0_reqack <= ~winner;
            bus.m1_reqack <= winner;
            owner         <= winner;
            lastGrant     <= winner;
            busy          <= 1'b1;
            if (winner) grant_cnt1 <= grant_cnt1 + 32'd1;
            else        grant_cnt0 <= grant_cnt0 + 32'd1;
            state         <= StReq;
          end
        end
        StReq: begin
          // A response arriving together with the ack is picked up from RESP instead.
          if (bus.c_reqack) begin
            bus.c_reqcyc <= 1'b0;
            state        <= StResp;
          end
        end
        StResp: begin
          if (bus.c_respcyc) begin
            respData       <= bus.c_resp;
            bus.m0_respcyc <= ~owner;
            bus.m1_respcyc <= owner;
            bus.c_respack  <= 1'b1;
            busy           <= 1'b0;
            state          <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // A requester must hold reqcyc until it has seen its reqack.
  m0HoldReq: assert property (@(posedge clk) disable iff (reset)
    bus.m0_reqcyc && !bus.m0_reqack |=> bus.m0_reqcyc)
    else $error("m0_reqcyc dropped before m0_reqack");
  m1HoldReq: assert property (@(posedge clk) disable iff (reset)
    bus.m1_reqcyc && !bus.m1_reqack |=> bus.m1_reqcyc)
    else $error("m1_reqcyc dropped before m1_reqack");
  oneRespPort: assert property (@(posedge clk) !(bus.m0_respcyc && bus.m1_respcyc))
    else $error("response delivered to both ports");

endmodule
